// File: rtl/router_out_sched.sv
// rtl/router_out_sched.sv - round-robin packet scheduler merging three router channels onto one valid/ready link
// Parity checking is present only when ROUTER_SCHED_PARITY_EN is defined; otherwise parity_err is tied low.
module router_out_sched #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    valid_out,
    input  logic [DW-1:0] data_out_0,
    input  logic [DW-1:0] data_out_1,
    input  logic [DW-1:0] data_out_2,
    output logic [2:0]    read_enb,
    input  logic          link_ready,
    output logic          link_valid,
    output logic [DW-1:0] link_data,
    output logic          link_sop,
    output logic          link_eop,
    output logic [1:0]    link_ch,
    output logic          parity_err,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_t;
    localparam int LW = DW - 2;
    localparam logic [LW:0] REM_ONE = {{LW{1'b0}}, 1'b1};

    state_t        r_state;
    logic [1:0]    r_ch;
    logic [1:0]    r_rr_ptr;
    logic [LW:0]   r_remain;
    logic          r_inflight;
    logic          r_inf_sop;
    logic          r_inf_eop;
    logic [1:0]    r_inf_ch;
    logic [DW-1:0] r_mem_data [2];
    logic [1:0]    r_mem_ch [2];
    logic [1:0]    r_mem_sop;
    logic [1:0]    r_mem_eop;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic [DW-1:0] w_cap_data;
    logic [1:0]    w_p1;
    logic [1:0]    w_p2;
    logic [1:0]    w_grant;
    logic          w_pop;
    logic          w_room;
    logic          w_rd;

    function automatic logic [1:0] f_next(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    always_comb begin
        w_p1 = f_next(r_rr_ptr);
        w_p2 = f_next(w_p1);
        if (valid_out[r_rr_ptr])
            w_grant = r_rr_ptr;
        else if (valid_out[w_p1])
            w_grant = w_p1;
        else
            w_grant = w_p2;
    end

    // Byte returned by the FIFO read issued last cycle
    always_comb begin
        case (r_inf_ch)
            2'd1:    w_cap_data = data_out_1;
            2'd2:    w_cap_data = data_out_2;
            default: w_cap_data = data_out_0;
        endcase
    end

    assign w_pop  = link_valid & link_ready;
    assign w_room = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_rd   = ((r_state == HDR) | ((r_state == BODY) & (r_remain != '0)))
                    & valid_out[r_ch] & w_room;
    assign read_enb = w_rd ? (3'b001 << r_ch) : 3'b000;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ch       <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_inf_sop  <= 1'b0;
            r_inf_eop  <= 1'b0;
            r_inf_ch   <= 2'd0;
        end else begin
            r_inflight <= w_rd;
            r_inf_sop  <= w_rd & (r_state == HDR);
            r_inf_eop  <= w_rd & (r_state == BODY) & (r_remain == REM_ONE);
            r_inf_ch   <= r_ch;
            case (r_state)
                IDLE: begin
                    if (|valid_out) begin
                        r_ch     <= w_grant;
                        r_rr_ptr <= f_next(w_grant);
                        r_state  <= HDR;
                    end
                end
                HDR: begin
                    if (w_rd)
                        r_state <= HWAIT;
                end
                HWAIT: begin
                    // payload bytes plus the trailing parity byte
                    r_remain <= {1'b0, w_cap_data[DW-1:2]} + REM_ONE;
                    r_state  <= BODY;
                end
                BODY: begin
                    if (w_rd) begin
                        r_remain <= r_remain - REM_ONE;
                        if (r_remain == REM_ONE)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_ch[0]   <= 2'd0;
            r_mem_ch[1]   <= 2'd0;
            r_mem_sop     <= 2'b00;
            r_mem_eop     <= 2'b00;
        end else begin
            if (r_inflight) begin
                r_mem_data[r_wr_ptr] <= w_cap_data;
                r_mem_ch[r_wr_ptr]   <= r_inf_ch;
                r_mem_sop[r_wr_ptr]  <= r_inf_sop;
                r_mem_eop[r_wr_ptr]  <= r_inf_eop;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign link_valid = (r_count != 2'd0);
    assign link_data  = r_mem_data[r_rd_ptr];
    assign link_ch    = r_mem_ch[r_rd_ptr];
    assign link_sop   = link_valid & r_mem_sop[r_rd_ptr];
    assign link_eop   = link_valid & r_mem_eop[r_rd_ptr];

`ifdef ROUTER_SCHED_PARITY_EN
    logic [DW-1:0] r_par_acc;
    logic          r_par_err;

    // Accumulator restarts on each header so back-to-back packets stay independent
    always_ff @(posedge clock) begin
        if (reset) begin
            r_par_acc <= '0;
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= r_inflight & r_inf_eop & (w_cap_data != r_par_acc);
            if (r_inflight & ~r_inf_eop)
                r_par_acc <= r_inf_sop ? w_cap_data : (r_par_acc ^ w_cap_data);
        end
    end

    assign parity_err = r_par_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_sched.sv
// tb/tb_router_out_sched.sv - self-checking bench for router_out_sched with a router FIFO model and packet-level reference
module tb_router_out_sched;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] valid_out = 3'b000;
    logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
    logic [2:0] read_enb;
    logic       link_ready = 1'b1;
    logic       link_valid;
    logic [7:0] link_data;
    logic       link_sop, link_eop;
    logic [1:0] link_ch;
    logic       parity_err, busy;

    int checks = 0;
    int failures = 0;

`ifdef ROUTER_SCHED_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    router_out_sched #(.DW(8)) dut (
        .clock(clock), .reset(reset), .valid_out(valid_out),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb(read_enb), .link_ready(link_ready), .link_valid(link_valid),
        .link_data(link_data), .link_sop(link_sop), .link_eop(link_eop),
        .link_ch(link_ch), .parity_err(parity_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Router FIFO model: bytes per channel, plus packet lengths for the reference scheduler
    logic [7:0]  rq [3][$];
    logic [7:0]  pb [3][$];
    int          plen [3][$];
    logic [11:0] exp_q [$];
    logic [11:0] rx [$];
    logic [2:0]  hold = 3'b000;
    logic [2:0]  pend = 3'b000;
    logic [7:0]  pop_b;
    int cyc = 0;
    int empty_rd = 0;

    always @(negedge clock) pend = read_enb;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (reset) begin
            for (int c = 0; c < 3; c++) rq[c].delete();
            pend = 3'b000;
            data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (pend[c]) begin
                    if (rq[c].size() == 0) empty_rd++;
                    else begin
                        pop_b = rq[c].pop_front();
                        case (c)
                            0: data_out_0 = pop_b;
                            1: data_out_1 = pop_b;
                            default: data_out_2 = pop_b;
                        endcase
                    end
                end
            end
        end
        for (int c = 0; c < 3; c++) valid_out[c] = (rq[c].size() > 0) && !hold[c];
    end

    // Link monitor: accepted beats, stall stability, read strobes, buffer occupancy, parity pulses
    int rd_cnt [3];
    int last_rd [3];
    int multi_hot = 0, stab_err = 0, pe_cnt = 0, pe_cyc = -1, max_occ = 0;
    int rd_d1 = 0, rd_d2 = 0, bt_cnt = 0, occ = 0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_beat = '0, mon_beat;

    always @(negedge clock) begin
        mon_beat = {link_ch, link_sop, link_eop, link_data};
        if (prev_stall && (!link_valid || mon_beat !== prev_beat)) stab_err++;
        prev_stall = link_valid && !link_ready;
        prev_beat = mon_beat;
        if (link_valid && link_ready) rx.push_back(mon_beat);
        if (!$onehot0(read_enb)) multi_hot++;
        for (int c = 0; c < 3; c++)
            if (read_enb[c]) begin rd_cnt[c]++; last_rd[c] = cyc; end
        occ = rd_d2 - bt_cnt;
        if (occ > max_occ) max_occ = occ;
        bt_cnt += (link_valid && link_ready) ? 1 : 0;
        rd_d2 = rd_d1;
        rd_d1 += (read_enb != 3'b000) ? 1 : 0;
        if (parity_err) begin pe_cnt++; pe_cyc = cyc; end
    end

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1; link_ready = 1'b1; hold = 3'b000;
        @(posedge clock); #2;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rq[c].delete(); pb[c].delete(); plen[c].delete();
            rd_cnt[c] = 0; last_rd[c] = -1;
        end
        rx.delete(); exp_q.delete();
        empty_rd = 0; multi_hot = 0; stab_err = 0; pe_cnt = 0; pe_cyc = -1; max_occ = 0;
        rd_d1 = 0; rd_d2 = 0; bt_cnt = 0; prev_stall = 1'b0;
    endtask

    task automatic add_pkt(input int c, input int len, input bit corrupt, input bit fixed);
        logic [7:0] b, par;
        b = {6'(len), fixed ? 2'b00 : 2'($urandom)};
        par = b; rq[c].push_back(b); pb[c].push_back(b);
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            par ^= b; rq[c].push_back(b); pb[c].push_back(b);
        end
        if (corrupt) par ^= 8'h01;
        rq[c].push_back(par); pb[c].push_back(par);
        plen[c].push_back(len);
    endtask

    // Reference: whole packets, round-robin over channels with packets left, pointer starting at 0
    task automatic build_expected();
        int ptr, ch, n;
        ptr = 0;
        exp_q.delete();
        while (plen[0].size() + plen[1].size() + plen[2].size() > 0) begin
            ch = ptr;
            if (plen[ch].size() == 0) ch = (ch + 1) % 3;
            if (plen[ch].size() == 0) ch = (ch + 1) % 3;
            n = plen[ch].pop_front() + 2;
            for (int i = 0; i < n; i++)
                exp_q.push_back({2'(ch), (i == 0), (i == n - 1), pb[ch].pop_front()});
            ptr = (ch + 1) % 3;
        end
    endtask

    task automatic run_until(input int n, input bit rand_ready, output bit ok);
        int t;
        t = 0;
        while (rx.size() < n && t < 3000) begin
            @(posedge clock); #2;
            link_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            t++;
        end
        ok = (rx.size() >= n);
        link_ready = 1'b1;
        repeat (6) @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({read_enb, link_valid, link_data, link_sop, link_eop, link_ch, parity_err, busy} !== 17'd0) begin
            failures++;
            $display("FAIL reset_values got read_enb=%b valid=%b data=%h sop=%b eop=%b ch=%0d perr=%b busy=%b want all zero",
                     read_enb, link_valid, link_data, link_sop, link_eop, link_ch, parity_err, busy);
        end
    endtask

    task automatic test_single();
        int t0; int rdc [$]; int tlv; bit ok;
        do_reset();
        add_pkt(0, 3, 1'b0, 1'b1);
        build_expected();
        t0 = -1; tlv = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid_out[0] && t0 < 0) t0 = cyc;
            if (read_enb[0]) rdc.push_back(cyc);
            if (link_valid && tlv < 0) tlv = cyc;
        end
        checks++;
        if (rdc.size() < 2 || rdc[0] - t0 != 1) begin
            failures++; $display("FAIL single_hdr_read_latency got=%0d want=1", (rdc.size() > 0) ? rdc[0] - t0 : -1);
        end
        checks++;
        if (rdc.size() < 2 || rdc[1] - t0 != 3) begin
            failures++; $display("FAIL single_first_payload_read got=%0d want=3", (rdc.size() > 1) ? rdc[1] - t0 : -1);
        end
        checks++;
        if (tlv - t0 != 3) begin failures++; $display("FAIL single_link_valid_latency got=%0d want=3", tlv - t0); end
        run_until(exp_q.size(), 1'b0, ok);
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL single_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL single_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
        checks++;
        if (pe_cnt != 0) begin failures++; $display("FAIL single_parity_err got=%0d pulses want=0", pe_cnt); end
    endtask

    task automatic test_all_channels();
        bit ok;
        do_reset();
        for (int c = 0; c < 3; c++) add_pkt(c, 2, 1'b0, 1'b0);
        add_pkt(0, 2, 1'b0, 1'b0);
        build_expected();
        run_until(exp_q.size(), 1'b0, ok);
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL allch_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL allch_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
        checks++;
        if (multi_hot != 0) begin failures++; $display("FAIL allch_multi_hot got=%0d want=0", multi_hot); end
    endtask

    task automatic test_backpressure();
        int t; int late_rd; bit ok;
        do_reset();
        add_pkt(0, 12, 1'b0, 1'b0);
        build_expected();
        t = 0;
        while (rx.size() < 3 && t < 50) begin @(posedge clock); t++; end
        #2; link_ready = 1'b0;
        late_rd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i >= 2 && read_enb != 3'b000) late_rd++;
        end
        run_until(exp_q.size(), 1'b0, ok);
        checks++;
        if (late_rd != 0) begin failures++; $display("FAIL bp_reads_while_full got=%0d want=0", late_rd); end
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL bp_stall_stability got=%0d changes want=0", stab_err); end
        checks++;
        if (max_occ > 2) begin failures++; $display("FAIL bp_occupancy got=%0d want<=2", max_occ); end
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL bp_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_parity();
        bit ok; int want_cnt, want_cyc;
        do_reset();
        add_pkt(1, 3, 1'b0, 1'b0);
        add_pkt(2, 4, 1'b1, 1'b0);
        build_expected();
        run_until(exp_q.size(), 1'b1, ok);
        want_cnt = PAR_EN ? 1 : 0;
        want_cyc = PAR_EN ? last_rd[2] + 2 : -1;
        checks++;
        if (pe_cnt != want_cnt) begin failures++; $display("FAIL parity_pulse_count got=%0d want=%0d", pe_cnt, want_cnt); end
        checks++;
        if (pe_cyc != want_cyc) begin failures++; $display("FAIL parity_pulse_cycle got=%0d want=%0d", pe_cyc, want_cyc); end
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL parity_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL parity_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_underrun();
        int t; int stray; int idle; bit ok;
        do_reset();
        add_pkt(1, 5, 1'b0, 1'b0);
        add_pkt(2, 2, 1'b0, 1'b0);
        build_expected();
        t = 0;
        while (rd_cnt[1] < 3 && t < 50) begin @(negedge clock); t++; end
        hold[1] = 1'b1;
        stray = 0; idle = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (read_enb != 3'b000) stray++;
            if (!busy) idle++;
        end
        hold[1] = 1'b0;
        run_until(exp_q.size(), 1'b0, ok);
        checks++;
        if (stray != 0) begin failures++; $display("FAIL underrun_reads got=%0d want=0", stray); end
        checks++;
        if (idle != 0) begin failures++; $display("FAIL underrun_grant_held got=%0d idle cycles want=0", idle); end
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL underrun_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL underrun_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int t; bit ok;
        do_reset();
        add_pkt(1, 10, 1'b0, 1'b0);
        t = 0;
        while (rd_cnt[1] < 5 && t < 50) begin @(negedge clock); t++; end
        do_reset();
        @(negedge clock);
        checks++;
        if ({read_enb, link_valid, busy} !== 5'd0) begin
            failures++; $display("FAIL midreset_outputs got read_enb=%b valid=%b busy=%b want 000 0 0", read_enb, link_valid, busy);
        end
        @(posedge clock); #2;
        add_pkt(0, 3, 1'b0, 1'b0);
        add_pkt(2, 3, 1'b0, 1'b0);
        build_expected();
        run_until(exp_q.size(), 1'b0, ok);
        checks++;
        if (!ok || rx.size() != exp_q.size()) begin
            failures++; $display("FAIL midreset_beat_count got=%0d want=%0d", rx.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_beat[%0d] got=%h want=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok; int len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int c = 0; c < 3; c++)
                for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                    case ($urandom_range(0, 3))
                        0: len = 0;
                        1: len = 63;
                        default: len = int'($urandom_range(1, 12));
                    endcase
                    add_pkt(c, len, 1'b0, 1'b0);
                end
            build_expected();
            run_until(exp_q.size(), 1'b1, ok);
            checks++;
            if (!ok || rx.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_beat_count got=%0d want=%0d", it, rx.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
                checks++;
                if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_beat[%0d] got=%h want=%h", it, i, rx[i], exp_q[i]); end
            end
            checks++;
            if ({stab_err, multi_hot, empty_rd, pe_cnt} != 0 || max_occ > 2) begin
                failures++;
                $display("FAIL rand%0d_protocol got stab=%0d multihot=%0d emptyrd=%0d perr=%0d occ=%0d want 0 0 0 0 <=2",
                         it, stab_err, multi_hot, empty_rd, pe_cnt, max_occ);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_backpressure();
        test_parity();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/router_out_sched.md
# router_out_sched

Packet-level output scheduler for the 1x3 router: merges the three router output channels onto one shared 8-bit downstream link. Round-robin arbitration between non-empty channels at packet boundaries, drives `read_enb` into the selected output FIFO, and buffers bytes in a 2-entry skid buffer behind a valid/ready link. Sits directly after the router's `valid_out_x`/`data_out_x`/`read_enb_x` ports.

## Interface
- `DW`, 8, data width; the header length field is bits [DW-1:2].
- `clock`  in  1  system clock; every flop is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_out`  in  3  router channel non-empty flags, bit i = channel i.
- `data_out_0`, `data_out_1`, `data_out_2`  in  DW each  router FIFO read data, valid the cycle after the matching `read_enb` bit.
- `read_enb`  out  3  FIFO read strobes. One-hot or zero.
- `link_ready`  in  1  downstream accepts the beat.
- `link_valid`  out  1  beat present on the link.
- `link_data`  out  DW  beat data.
- `link_sop`  out  1  beat is the packet header.
- `link_eop`  out  1  beat is the parity byte.
- `link_ch`  out  2  source channel of the current beat.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch.
- `busy`  out  1  grant held (any state other than IDLE).

## Operation
- Packet format: header (length L = header[7:2], 0..63), then L payload bytes, then 1 parity byte. Total L+2 bytes.
- FSM states and transitions:
  - IDLE -> HDR when any `valid_out` bit is high. The grant goes to the first set bit searching from `rr_ptr`. On grant, `rr_ptr` is set to grant+1 mod 3.
  - HDR: assert `read_enb[ch]` once `valid_out[ch]` is high and there is buffer room. Then -> HWAIT.
  - HWAIT: capture the header, load `remain = L+1`. Then -> BODY.
  - BODY: assert `read_enb[ch]` each cycle that `valid_out[ch]` is high, there is room, and `remain != 0`. Decrement `remain` on each read. -> IDLE in the cycle after the read that takes `remain` to 0.
- Room rule: a read may issue when `occupancy - pop + inflight < 2`.
  - `pop = link_valid & link_ready`.
  - `inflight` = a read was issued last cycle.
- Underrun: if `valid_out[ch]` is low mid-packet, pause. No read, no state change, grant held indefinitely.
- Skid buffer:
  - 2-entry FIFO. Each entry holds data, sop, eop, ch.
  - Capture happens the cycle after `read_enb`. sop marks the first byte of a packet; eop marks the (L+2)th byte.
- Link handshake: `link_data`/`sop`/`eop`/`ch` hold stable while `link_valid & !link_ready`. `link_valid` is never withdrawn without acceptance.
- Parity: running XOR over the header and payload bytes. Compared with the parity byte when that byte is captured.

## Timing
- Reset values:
  - `read_enb` = 000, `link_valid` = 0, `link_data` = 0x00.
  - `link_sop`, `link_eop`, `link_ch`, `parity_err`, `busy` all 0.
  - `rr_ptr` = 0. FSM in IDLE. Buffer empty, `remain` = 0.
- Latency with `link_ready` held high, where `valid_out[0]` is first high in IDLE at cycle 0:
  - `read_enb[0]` is high in cycle 1.
  - `link_valid`/`link_sop` are high in cycle 3.
  - The first payload read is in cycle 3. There is a 1-cycle read bubble after the header read.
- Steady state: 1 byte per cycle. A packet of L bytes occupies L+4 cycles from grant to last read. There is a 1-cycle IDLE bubble between packets.
- Simultaneous requests: channels 0,1,2 all pending from reset are served in order 0,1,2,0.
- Reset asserted mid-packet:
  - Next cycle matches the reset values above. Buffered bytes are dropped.
  - The unread remainder in the router FIFO is not drained. The router must be reset together with this block.
- `parity_err` is registered. It is high in the cycle after the parity byte is captured, independent of link backpressure.

## Configuration
- `ROUTER_SCHED_PARITY_EN` defined: XOR accumulator and comparator are present; `parity_err` pulses as specified.
- Not defined: no parity logic, `parity_err` tied to 0. All other behaviour is identical.

## Test plan
- Single packet on ch0: header 0x0C (L=3), payload 11,22,33, parity 0x0C^11^22^33, `link_ready`=1 -> beats 0C,11,22,33,parity. sop on 0C, eop on parity, `link_ch`=0, first `link_valid` at cycle 3, `parity_err`=0.
- All 3 channels loaded from reset, 2-byte payloads each -> packets leave whole, in order ch0, ch1, ch2. No interleaving. `read_enb` is never multi-hot.
- `link_ready` low for 5 cycles mid-payload -> at most 2 buffered bytes, no further `read_enb`, `link_data` held stable. On resume, no byte is lost or duplicated.
- Corrupt parity byte (correct ^ 0x01), macro defined -> `parity_err` pulses exactly once, one cycle after the parity byte is captured. With the macro undefined -> `parity_err` stays 0.
- ch1 `valid_out` drops after 2 of 5 payload bytes for 10 cycles while ch2 is pending -> grant stays on ch1, reads resume when `valid_out[1]` returns, ch2 is served afterwards.
- `reset` asserted during BODY of an L=10 packet -> next cycle: `read_enb`=0, `link_valid`=0, `busy`=0. After reset deasserts, the next grant starts at ch0.
